// File: rtl/line_data_memory_if.sv
// Memory-port bundle between the data cache controller and the line memory.
//   addr_i   : byte address of the request (offset bits [4:0] ignored)
//   data_i   : line to write
//   enable_i : request valid
//   write_i  : 1 = write, 0 = read; qualified by enable_i
//   ack_o    : one-cycle completion pulse
//   data_o   : last line returned by a read
//   busy_o   : a request is in flight (acceptance through the dead cycle)
// The master modport is the requester side (cache), the slave is the memory.
interface line_data_memory_if #(
  parameter int LINE_W = 256
);
  logic [31:0]       addr_i;
  logic [LINE_W-1:0] data_i;
  logic              enable_i;
  logic              write_i;
  logic              ack_o;
  logic [LINE_W-1:0] data_o;
  logic              busy_o;

  modport master (
    output addr_i, data_i, enable_i, write_i,
    input  ack_o, data_o, busy_o
  );

  modport slave (
    input  addr_i, data_i, enable_i, write_i,
    output ack_o, data_o, busy_o
  );
endinterface

// File: rtl/line_data_memory.sv
// Line-granular backing memory for the data cache's 256-bit memory port.
// A request is captured when enable_i is seen in IDLE; ack_o pulses exactly
// LATENCY cycles later, followed by one dead cycle before the next request
// can be taken, so accepted requests are spaced by at least LATENCY+2 cycles.
// Ports:
//   clk_i : clock, all logic on the rising edge
//   rst_i : synchronous active-high reset (array contents are kept)
//   bus   : line_data_memory_if.slave (address, write data, request, ack,
//           read data, busy)
// Parameters: LATENCY (1..255), DEPTH (power of two lines), LINE_W (bits).
module line_data_memory #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512,
  parameter int LINE_W  = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  line_data_memory_if.slave bus
);

  localparam int               IDX_W    = $clog2(DEPTH);
  localparam int               CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Captured request; held stable for the whole transaction so the requester
  // may change its inputs while we are waiting.
  logic [IDX_W-1:0]   idx_q;
  logic               wr_q;
  logic [LINE_W-1:0]  wdata_q;
  logic [LINE_W-1:0]  rdata_q;

  logic [IDX_W-1:0]   req_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic               capture;
  logic               rd_load;
  logic               mem_we;

  logic [LINE_W-1:0]  mem [DEPTH];

  // Upper address bits alias onto the same lines and the byte offset is
  // meaningless at line granularity, so only the index field is decoded.
  assign req_idx = bus.addr_i[5 +: IDX_W];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr_i[31:5+IDX_W], bus.addr_i[4:0]};

  // Next-state and control decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    rd_load = 1'b0;
    rd_idx  = idx_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.enable_i) begin
          capture = 1'b1;
          cnt_d   = CNT_INIT;
          if (LATENCY == 1) begin
            // No wait phase: the read data must already be loaded on the
            // edge that enters ACK, straight from the live address.
            state_d = ACK;
            rd_load = !bus.write_i;
            rd_idx  = req_idx;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        // <= rather than == so a corrupted count can never strand the FSM.
        if (cnt_q <= CNT_ONE) begin
          state_d = ACK;
          rd_load = !wr_q;
        end
      end
      ACK: begin
        // Writes commit on the edge that closes the ack cycle.
        mem_we  = wr_q;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latency counter.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture and registered read data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (capture) begin
        idx_q   <= req_idx;
        wr_q    <= bus.write_i;
        wdata_q <= bus.data_i;
      end
      if (rd_load) begin
        rdata_q <= mem[rd_idx];
      end
    end
  end

  // Line array. A reset landing on the ack edge drops the write.
  always_ff @(posedge clk_i) begin
    // NOTE: the array has no reset branch; clearing DEPTH lines would prevent
    // RAM inference and the contents are meant to survive reset.
    if (mem_we && !rst_i) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign bus.ack_o  = (state_q == ACK);
  assign bus.busy_o = (state_q != IDLE);
  assign bus.data_o = rdata_q;

endmodule

// File: tb/tb_line_data_memory.sv
// Directed bench for line_data_memory: a LATENCY=10 instance covers timing,
// back-to-back requests, aliasing, reset mid-write and input changes while
// waiting; a LATENCY=1 instance covers the shortest turnaround.
module tb_line_data_memory;

  localparam int LINE_W = 256;

  logic clk;
  logic rst;

  int n_assert = 0;
  int n_fail   = 0;

  line_data_memory_if #(.LINE_W(LINE_W)) bus  ();
  line_data_memory_if #(.LINE_W(LINE_W)) bus1 ();

  line_data_memory #(.LATENCY(10), .DEPTH(512), .LINE_W(LINE_W)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  line_data_memory #(.LATENCY(1), .DEPTH(512), .LINE_W(LINE_W)) u_dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [255:0] A5   = {32{8'hA5}};
  localparam logic [255:0] D1   = {8{32'h1111_0001}};
  localparam logic [255:0] D4   = {8{32'h4444_0004}};
  localparam logic [255:0] X    = {8{32'hC0DE_0001}};
  localparam logic [255:0] Z    = {8{32'h2222_0002}};
  localparam logic [255:0] Y    = {8{32'hBAD0_0003}};
  localparam logic [255:0] W    = {8{32'h5555_0005}};
  localparam logic [255:0] P    = {8{32'h6666_0006}};
  localparam logic [255:0] JUNK = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] Q    = {16{16'h1234}};

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One isolated request on the LATENCY=10 instance. k counts cycles after the
  // acceptance edge: ack only at k==9, busy through k==10, idle at k==11.
  // exp_rd is the data_o value required during the ack cycle. With chg set,
  // the inputs are scrambled three cycles after acceptance.
  task automatic txn(input logic [31:0] addr, input logic [255:0] wdata,
                     input logic wr, input logic [255:0] exp_rd,
                     input bit chg, input string tag);
    bus.addr_i   = addr;
    bus.data_i   = wdata;
    bus.write_i  = wr;
    bus.enable_i = 1'b1;
    tick();
    bus.enable_i = 1'b0;
    for (int k = 0; k < 12; k++) begin
      check({tag, "_ack"}, bus.ack_o, k == 9);
      check({tag, "_busy"}, bus.busy_o, k <= 10);
      if (k == 9) check({tag, "_data"}, bus.data_o, exp_rd);
      if (chg && k == 2) begin
        bus.addr_i  = 32'h0000_0220;
        bus.data_i  = JUNK;
        bus.write_i = 1'b0;
      end
      if (k < 11) tick();
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.addr_i    = '0;
    bus.data_i    = '0;
    bus.enable_i  = 1'b0;
    bus.write_i   = 1'b0;
    bus1.addr_i   = '0;
    bus1.data_i   = '0;
    bus1.enable_i = 1'b0;
    bus1.write_i  = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    check("rst_ack", bus.ack_o, 1'b0);
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_data", bus.data_o, '0);

    // Write then read back index 33; write ack leaves data_o at its reset 0.
    txn(32'h0000_0420, A5, 1'b1, '0, 1'b0, "wr33");
    txn(32'h0000_0420, '0, 1'b0, A5, 1'b0, "rd33");

    // Preload index 4, then hold enable high: write index 2, switch to a read
    // of index 4 during DONE. Acks at k=9 and k=21, idle only at k=11 and 23.
    txn(32'h0000_0080, D4, 1'b1, A5, 1'b0, "wr4");
    bus.addr_i   = 32'h0000_0040;
    bus.data_i   = D1;
    bus.write_i  = 1'b1;
    bus.enable_i = 1'b1;
    tick();
    for (int k = 0; k < 24; k++) begin
      check("b2b_ack", bus.ack_o, (k == 9) || (k == 21));
      check("b2b_busy", bus.busy_o, !((k == 11) || (k == 23)));
      if (k == 21) check("b2b_rd4", bus.data_o, D4);
      if (k == 10) begin
        bus.write_i = 1'b0;
        bus.addr_i  = 32'h0000_0080;
      end
      if (k == 21) bus.enable_i = 1'b0;
      if (k < 23) tick();
    end
    txn(32'h0000_0040, '0, 1'b0, D1, 1'b0, "rd2");

    // Aliasing: high bits and byte offset are ignored.
    txn(32'h0000_0020, X, 1'b1, D1, 1'b0, "wr1");
    txn(32'h0000_4020, '0, 1'b0, X, 1'b0, "alias_hi");
    txn(32'h0000_003F, '0, 1'b0, X, 1'b0, "alias_off");

    // Reset five cycles into a write: no ack, outputs cleared, old data kept.
    txn(32'h0000_0100, Z, 1'b1, X, 1'b0, "wr8");
    bus.addr_i   = 32'h0000_0100;
    bus.data_i   = Y;
    bus.write_i  = 1'b1;
    bus.enable_i = 1'b1;
    tick();
    bus.enable_i = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_ack", bus.ack_o, 1'b0);
    check("rstmid_busy", bus.busy_o, 1'b0);
    check("rstmid_data", bus.data_o, '0);
    for (int k = 0; k < 8; k++) begin
      check("rstmid_noack", bus.ack_o, 1'b0);
      tick();
    end
    txn(32'h0000_0100, '0, 1'b0, Z, 1'b0, "rd8");

    // Inputs scrambled during WAIT: index 16 gets W, index 17 keeps P.
    txn(32'h0000_0220, P, 1'b1, Z, 1'b0, "wr17");
    txn(32'h0000_0200, W, 1'b1, Z, 1'b1, "wr16chg");
    txn(32'h0000_0200, '0, 1'b0, W, 1'b0, "rd16");
    txn(32'h0000_0220, '0, 1'b0, P, 1'b0, "rd17");

    // LATENCY=1: ack right after acceptance, then DONE, then IDLE.
    bus1.addr_i   = 32'h0000_0420;
    bus1.data_i   = Q;
    bus1.write_i  = 1'b1;
    bus1.enable_i = 1'b1;
    tick();
    check("l1_wr_ack", bus1.ack_o, 1'b1);
    check("l1_wr_data", bus1.data_o, '0);
    bus1.enable_i = 1'b0;
    tick();
    check("l1_wr_done_ack", bus1.ack_o, 1'b0);
    check("l1_wr_done_busy", bus1.busy_o, 1'b1);
    tick();
    check("l1_wr_idle_busy", bus1.busy_o, 1'b0);

    // Read with enable held: accepted at T, next acceptance at T+3.
    bus1.write_i  = 1'b0;
    bus1.enable_i = 1'b1;
    tick();
    check("l1_rd_ack", bus1.ack_o, 1'b1);
    check("l1_rd_data", bus1.data_o, Q);
    tick();
    check("l1_done_ack", bus1.ack_o, 1'b0);
    check("l1_done_busy", bus1.busy_o, 1'b1);
    tick();
    check("l1_idle_ack", bus1.ack_o, 1'b0);
    check("l1_idle_busy", bus1.busy_o, 1'b0);
    tick();
    check("l1_reacc_ack", bus1.ack_o, 1'b1);
    check("l1_reacc_data", bus1.data_o, Q);
    bus1.enable_i = 1'b0;
    tick();
    check("l1_end_ack", bus1.ack_o, 1'b0);
    tick();
    check("l1_end_busy", bus1.busy_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
